// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Glyphs are active-low, bit 0 = segment A ... bit 6 = segment G.
package seg_pkg;

  typedef enum logic {BLANK, SHOW} seg_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Entry 15 (F) first, entry 0 last.
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg_scan_controller_if.sv
// Display data/pin bundle between the value source (master) and the scan controller (slave).
interface seg_scan_controller_if;

  logic [31:0] value;
  logic [7:0]  digit_en;
  logic [7:0]  dp_in;
  logic [7:0]  AN;
  logic [6:0]  seg;
  logic        DP;
  logic        frame_tick;

  modport master (
    output value, digit_en, dp_in,
    input  AN, seg, DP, frame_tick
  );

  modport slave (
    input  value, digit_en, dp_in,
    output AN, seg, DP, frame_tick
  );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational nibble -> active-low hex glyph lookup.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] glyph_o
);

  always_comb begin
    glyph_o = SEG_GLYPHS[nibble_i];
  end

endmodule

// File: rtl/seg_scan_controller.sv
// 8-digit common-anode scan scheduler: one dwell counter, per-slot blanking, per-frame snapshot.
// Optional leading-zero blanking when SEG_SCAN_LZB_EN is defined.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned NUM_DIGITS   = 8
) (
  input logic               CLK_IN,
  input logic               clear,
  seg_scan_controller_if.slave bus
);

  localparam int unsigned    CntW      = $clog2(DWELL_CYCLES);
  localparam logic [CntW-1:0] CntLast   = CntW'(DWELL_CYCLES - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [2:0]     IdxLast   = 3'(NUM_DIGITS - 1);

  seg_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [31:0]     val_snap_q, val_snap_d;
  logic [7:0]      en_snap_q, en_snap_d;
  logic [7:0]      dp_snap_q, dp_snap_d;
  logic [7:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic            tick_q, tick_d;

  logic            slot_end;
  logic            frame_end;
  logic            shown;
  logic [3:0]      nibble;
  logic [6:0]      glyph;

  seg_hex_decode u_decode (
    .nibble_i (nibble),
    .glyph_o  (glyph)
  );

  always_comb begin
    slot_end  = (cnt_q == CntLast);
    frame_end = slot_end && (idx_q == IdxLast);

    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) idx_d = (idx_q == IdxLast) ? 3'd0 : idx_q + 3'd1;

    state_d = state_q;
    unique case (state_q)
      BLANK:   if (cnt_q == BlankLast) state_d = SHOW;
      SHOW:    if (slot_end) state_d = BLANK;
      default: state_d = BLANK;
    endcase

    // Snapshot lands on the same edge that starts digit 0's blanking.
    val_snap_d = val_snap_q;
    en_snap_d  = en_snap_q;
    dp_snap_d  = dp_snap_q;
    if (frame_end) begin
      val_snap_d = bus.value;
      en_snap_d  = bus.digit_en;
      dp_snap_d  = bus.dp_in;
    end
    tick_d = frame_end;

    nibble = val_snap_q[{idx_q, 2'b00} +: 4];
    shown  = en_snap_q[idx_q];
`ifdef SEG_SCAN_LZB_EN
    if ((idx_q != 3'd0) && ((val_snap_q >> {idx_q, 2'b00}) == 32'd0)) shown = 1'b0;
`endif

    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if ((state_q == SHOW) && shown) begin
      an_d[idx_q] = 1'b0;
      seg_d       = glyph;
      dp_d        = ~dp_snap_q[idx_q];
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (clear) begin
      state_q    <= BLANK;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      val_snap_q <= 32'd0;
      en_snap_q  <= 8'd0;
      dp_snap_q  <= 8'd0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      val_snap_q <= val_snap_d;
      en_snap_q  <= en_snap_d;
      dp_snap_q  <= dp_snap_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      tick_q     <= tick_d;
    end
  end

  assign bus.AN         = an_q;
  assign bus.seg        = seg_q;
  assign bus.DP         = dp_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller with DWELL_CYCLES=10, BLANK_CYCLES=2.
// Build with +define+SEG_SCAN_LZB_EN to exercise leading-zero blanking.
module tb_seg_scan_controller;

  localparam int Dwell = 10;
  localparam int Blank = 2;
  localparam int Frame = Dwell * 8;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
    logic       rst;
  } exp_t;

  logic  clk;
  logic  clear;
  string phase;
  int    n_tests;
  int    n_fail;

  exp_t        exp_q[$];
  int unsigned n;
  logic [31:0] m_val;
  logic [7:0]  m_en;
  logic [7:0]  m_dp;
  int          cyc;
  int          last_tick;

  seg_scan_controller_if bus ();

  seg_scan_controller #(
    .DWELL_CYCLES (Dwell),
    .BLANK_CYCLES (Blank),
    .NUM_DIGITS   (8)
  ) dut (
    .CLK_IN (clk),
    .clear  (clear),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic bit ref_shown(input int d);
    bit any_nz;
    if (!m_en[d]) return 1'b0;
    any_nz = (d == 0);
    for (int j = d; j < 8; j++) if (m_val[4*j +: 4] != 4'h0) any_nz = 1'b1;
`ifdef SEG_SCAN_LZB_EN
    return any_nz;
`else
    return 1'b1;
`endif
  endfunction

  // Reference model: outputs after edge n reflect the scan position after edge n-1.
  always @(posedge clk) begin
    exp_t e;
    int   m;
    int   pos;
    int   d;
    e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, tick: 1'b0, rst: 1'b0};
    if (clear) begin
      n     = 0;
      m_val = 32'd0;
      m_en  = 8'd0;
      m_dp  = 8'd0;
      e.rst = 1'b1;
    end else begin
      n++;
      m   = int'(n) - 1;
      pos = m % Dwell;
      d   = (m / Dwell) % 8;
      if (pos >= Blank && ref_shown(d)) begin
        e.an    = 8'hFF;
        e.an[d] = 1'b0;
        e.seg   = ref_glyph(m_val[4*d +: 4]);
        e.dp    = ~m_dp[d];
      end
      e.tick = (n % Frame == 0);
      if (n % Frame == 0) begin
        m_val = bus.value;
        m_en  = bus.digit_en;
        m_dp  = bus.dp_in;
      end
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc++;
      check_eq({phase, ".an"}, 32'(bus.AN), 32'(e.an));
      check_eq({phase, ".seg"}, 32'(bus.seg), 32'(e.seg));
      check_eq({phase, ".dp"}, 32'(bus.DP), 32'(e.dp));
      check_eq({phase, ".tick"}, 32'(bus.frame_tick), 32'(e.tick));
      if (e.rst) last_tick = -1;
      if (bus.frame_tick === 1'b1) begin
        if (last_tick >= 0) check_eq({phase, ".tick_period"}, 32'(cyc - last_tick), 32'(Frame));
        last_tick = cyc;
      end
    end
  end

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    cyc          = 0;
    last_tick    = -1;
    phase        = "reset";
    clear        = 1'b1;
    bus.value    = 32'h76543210;
    bus.digit_en = 8'hFF;
    bus.dp_in    = 8'h00;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    phase = "scan";
    repeat (175) @(negedge clk);

    // Now mid-SHOW of a slot.
    phase = "mid_reset";
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (170) @(negedge clk);

    phase     = "snapshot";
    bus.value = 32'h0;
    repeat (75) @(negedge clk);
    repeat (30) @(negedge clk);
    bus.value = 32'hFFFF_FFFF;
    repeat (170) @(negedge clk);

    phase        = "enables";
    bus.value    = 32'h76543210;
    bus.digit_en = 8'h05;
    bus.dp_in    = 8'h04;
    repeat (170) @(negedge clk);

    phase        = "lzb_a30";
    bus.value    = 32'h00000A30;
    bus.digit_en = 8'hFF;
    bus.dp_in    = 8'h00;
    repeat (170) @(negedge clk);

    phase     = "lzb_zero";
    bus.value = 32'h0;
    repeat (170) @(negedge clk);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
